// File: rtl/sram_xbar_pkg.sv
// Shared types, defaults and helpers for the SRAM crossbar.
// Build option: SRAM_XBAR_FIXED_PRI_EN selects fixed-priority arbitration.
package sram_xbar_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 16;
    localparam int SRAM_LAT   = 1;

    typedef logic [3:0]  be_t;
    typedef logic [31:0] word_t;

    function automatic int clog2_safe(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sram_xbar_rr_arb.sv
// Per-bank arbiter: combinational one-hot grant, round-robin by default,
// lowest-index fixed priority when SRAM_XBAR_FIXED_PRI_EN is defined.
module sram_xbar_rr_arb
    import sram_xbar_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

`ifdef SRAM_XBAR_FIXED_PRI_EN
    logic unused_clk;
    assign unused_clk = clk;

    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
        if (rst) gnt = '0;
    end
`else
    localparam int PW = (N > 1) ? clog2_safe(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;
    int            idx;

    // Search starts at ptr and wraps; the first requester found wins.
    always_comb begin
        gnt   = '0;
        gidx  = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gidx     = PW'(idx);
            end
        end
        if (rst) gnt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (|gnt) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
        end
    end
`endif

endmodule

// File: rtl/sram_xbar.sv
// NUM_M x NUM_B crossbar onto word-interleaved single-cycle SRAM banks.
// Build option: SRAM_XBAR_FIXED_PRI_EN (fixed priority instead of round-robin).
module sram_xbar
    import sram_xbar_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int NUM_B   = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BANK_AW = ADDR_W - 2 - clog2_safe(NUM_B)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_M-1:0]          m_req,
    input  logic [NUM_M*DATA_W/8-1:0] m_we,
    input  logic [NUM_M*ADDR_W-1:0]   m_addr,
    input  logic [NUM_M*DATA_W-1:0]   m_wdata,
    output logic [NUM_M-1:0]          m_gnt,
    output logic [NUM_M-1:0]          m_rvalid,
    output logic [NUM_M*DATA_W-1:0]   m_rdata,
    output logic [NUM_B-1:0]          b_cs,
    output logic [NUM_B*DATA_W/8-1:0] b_web,
    output logic [NUM_B*BANK_AW-1:0]  b_a,
    output logic [NUM_B*DATA_W-1:0]   b_di,
    input  logic [NUM_B*DATA_W-1:0]   b_do
);

    localparam int BE_W   = DATA_W / 8;
    localparam int BSEL_W = clog2_safe(NUM_B);
    localparam int BIW    = (BSEL_W > 0) ? BSEL_W : 1;

    logic [BIW-1:0]     m_bank      [NUM_M];
    logic [NUM_M-1:0]   bank_req    [NUM_B];
    logic [NUM_M-1:0]   bank_gnt    [NUM_B];
    logic [NUM_M-1:0]   rsp_vld_p1;
    logic [BIW-1:0]     rsp_bank_p1 [NUM_M];
    logic [2*NUM_M-1:0] unused_addr_lo;

    for (genvar m = 0; m < NUM_M; m++) begin : g_dec
        if (NUM_B > 1) begin : g_multi
            assign m_bank[m] = m_addr[m*ADDR_W+2 +: BIW];
        end else begin : g_single
            assign m_bank[m] = '0;
        end
        assign unused_addr_lo[2*m +: 2] = m_addr[m*ADDR_W +: 2];
    end

    always_comb begin
        for (int b = 0; b < NUM_B; b++) begin
            for (int m = 0; m < NUM_M; m++) begin
                bank_req[b][m] = m_req[m] && (m_bank[m] == BIW'(b));
            end
        end
    end

    for (genvar b = 0; b < NUM_B; b++) begin : g_arb
        sram_xbar_rr_arb #(.N(NUM_M)) u_arb (
            .clk (clk),
            .rst (rst),
            .req (bank_req[b]),
            .gnt (bank_gnt[b])
        );
    end

    // Request stage: grant routing and bank-side muxing, all combinational.
    always_comb begin
        m_gnt = '0;
        b_cs  = '0;
        b_web = '1;
        b_a   = '0;
        b_di  = '0;
        for (int b = 0; b < NUM_B; b++) begin
            m_gnt = m_gnt | bank_gnt[b];
            for (int m = 0; m < NUM_M; m++) begin
                if (bank_gnt[b][m]) begin
                    b_cs[b]                    = 1'b1;
                    b_web[b*BE_W +: BE_W]      = ~m_we[m*BE_W +: BE_W];
                    b_a[b*BANK_AW +: BANK_AW]  = m_addr[m*ADDR_W+2+BSEL_W +: BANK_AW];
                    b_di[b*DATA_W +: DATA_W]   = m_wdata[m*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Response stage: remember which bank each granted read went to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_p1 <= '0;
            for (int m = 0; m < NUM_M; m++) rsp_bank_p1[m] <= '0;
        end else begin
            for (int m = 0; m < NUM_M; m++) begin
                rsp_vld_p1[m] <= m_gnt[m] && (m_we[m*BE_W +: BE_W] == '0);
                if (m_gnt[m]) rsp_bank_p1[m] <= m_bank[m];
            end
        end
    end

    always_comb begin
        m_rvalid = rsp_vld_p1;
        m_rdata  = '0;
        for (int m = 0; m < NUM_M; m++) begin
            if (rsp_vld_p1[m]) begin
                m_rdata[m*DATA_W +: DATA_W] = b_do[int'(rsp_bank_p1[m])*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_sram_xbar.sv
// Directed bench for sram_xbar (2 masters, 2 behavioural SRAM banks) with a
// per-master read-data scoreboard and an independent bank-output model.
module tb_sram_xbar;

    logic        clk;
    logic        rst;
    logic [1:0]  m_req;
    logic [7:0]  m_we;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_gnt;
    logic [1:0]  m_rvalid;
    logic [63:0] m_rdata;
    logic [1:0]  b_cs;
    logic [7:0]  b_web;
    logic [25:0] b_a;
    logic [63:0] b_di;
    logic [63:0] b_do;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q [2][$];
    logic [31:0] model [int];

    sram_xbar #(
        .NUM_M (2), .NUM_B (2), .ADDR_W (16), .DATA_W (32), .BANK_AW (13)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_gnt    (m_gnt),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .b_cs     (b_cs),
        .b_web    (b_web),
        .b_a      (b_a),
        .b_di     (b_di),
        .b_do     (b_do)
    );

    for (genvar gb = 0; gb < 2; gb++) begin : g_sram
        logic [31:0] mem [0:8191];
        logic [31:0] dout;
        always @(posedge clk) begin
            if (b_cs[gb]) begin
                for (int k = 0; k < 4; k++) begin
                    if (!b_web[gb*4+k]) mem[b_a[gb*13 +: 13]][k*8 +: 8] <= b_di[gb*32+k*8 +: 8];
                end
                if (&b_web[gb*4 +: 4]) dout <= mem[b_a[gb*13 +: 13]];
            end
        end
        assign b_do[gb*32 +: 32] = dout;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int m, input logic req, input logic [3:0] we,
                       input logic [15:0] addr, input logic [31:0] d);
        m_req[m]          = req;
        m_we[m*4 +: 4]    = we;
        m_addr[m*16 +: 16] = addr;
        m_wdata[m*32 +: 32] = d;
    endtask

    // Checks one cycle at the falling edge, then advances to just after the next rising edge.
    task automatic cycle(input logic [1:0] exp_gnt, input string tag);
        logic        ecs;
        logic [3:0]  eweb;
        logic [12:0] ea;
        logic [31:0] edi;
        logic [31:0] ed;
        logic [15:0] ad;
        logic [3:0]  we;
        logic [31:0] wd;
        int          w;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk({63'b0, m_rvalid[m]}, {63'b0, q[m].size() > 0}, $sformatf("%s_rvalid%0d", tag, m));
            if (q[m].size() > 0) begin
                ed = q[m].pop_front();
                chk({32'b0, m_rdata[m*32 +: 32]}, {32'b0, ed}, $sformatf("%s_rdata%0d", tag, m));
            end else begin
                chk({32'b0, m_rdata[m*32 +: 32]}, 64'd0, $sformatf("%s_rdata_idle%0d", tag, m));
            end
        end
        chk({62'b0, m_gnt}, {62'b0, exp_gnt}, $sformatf("%s_gnt", tag));
        for (int b = 0; b < 2; b++) begin
            ecs = 1'b0; eweb = 4'hF; ea = '0; edi = '0;
            for (int m = 0; m < 2; m++) begin
                ad = m_addr[m*16 +: 16];
                if (exp_gnt[m] && (int'(ad[2]) == b)) begin
                    ecs  = 1'b1;
                    eweb = ~m_we[m*4 +: 4];
                    ea   = ad[15:3];
                    edi  = m_wdata[m*32 +: 32];
                end
            end
            chk({63'b0, b_cs[b]}, {63'b0, ecs}, $sformatf("%s_cs%0d", tag, b));
            chk({60'b0, b_web[b*4 +: 4]}, {60'b0, eweb}, $sformatf("%s_web%0d", tag, b));
            chk({51'b0, b_a[b*13 +: 13]}, {51'b0, ea}, $sformatf("%s_a%0d", tag, b));
            chk({32'b0, b_di[b*32 +: 32]}, {32'b0, edi}, $sformatf("%s_di%0d", tag, b));
        end
        for (int m = 0; m < 2; m++) begin
            if (exp_gnt[m]) begin
                ad = m_addr[m*16 +: 16];
                we = m_we[m*4 +: 4];
                wd = m_wdata[m*32 +: 32];
                w  = int'(ad[15:2]);
                if (we == 4'h0) begin
                    q[m].push_back(model.exists(w) ? model[w] : 32'h0);
                end else begin
                    if (!model.exists(w)) model[w] = 32'h0;
                    for (int k = 0; k < 4; k++) if (we[k]) model[w][k*8 +: 8] = wd[k*8 +: 8];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m_req = '0; m_we = '0; m_addr = '0; m_wdata = '0;
        #1;
        // Reset with both masters requesting: no grants, idle banks.
        drv(0, 1'b1, 4'h0, 16'h0000, 32'h0);
        drv(1, 1'b1, 4'h0, 16'h0010, 32'h0);
        repeat (3) cycle(2'b00, "rst");
        rst = 1'b0;
        m_req = '0;
        cycle(2'b00, "idle");

        drv(0, 1'b1, 4'hF, 16'h0008, 32'hDEADBEEF);
        cycle(2'b01, "s2_wr");
        drv(0, 1'b1, 4'h0, 16'h0008, 32'h0);
        cycle(2'b01, "s2_rd");
        m_req = '0;
        cycle(2'b00, "s2_rsp");

        drv(0, 1'b1, 4'b0011, 16'h0008, 32'h12345678);
        cycle(2'b01, "s3_wr");
        drv(0, 1'b1, 4'h0, 16'h0008, 32'h0);
        cycle(2'b01, "s3_rd");
        m_req = '0;
        cycle(2'b00, "s3_rsp");

        drv(0, 1'b1, 4'hF, 16'h0000, 32'h11111111);
        cycle(2'b01, "pre0");
        drv(0, 1'b0, 4'h0, 16'h0000, 32'h0);
        drv(1, 1'b1, 4'hF, 16'h0010, 32'hCAFEF00D);
        cycle(2'b10, "pre1");
        drv(1, 1'b1, 4'hF, 16'h0004, 32'hA5A50004);
        cycle(2'b10, "pre2");
        m_req = '0;
        cycle(2'b00, "pre_idle");

        drv(0, 1'b1, 4'h0, 16'h0000, 32'h0);
        drv(1, 1'b1, 4'h0, 16'h0010, 32'h0);
`ifdef SRAM_XBAR_FIXED_PRI_EN
        repeat (4) cycle(2'b01, "s4");
`else
        cycle(2'b01, "s4_c0");
        cycle(2'b10, "s4_c1");
        cycle(2'b01, "s4_c2");
        cycle(2'b10, "s4_c3");
`endif
        m_req = '0;
        cycle(2'b00, "s4_rsp");

        drv(0, 1'b1, 4'h0, 16'h0000, 32'h0);
        drv(1, 1'b1, 4'h0, 16'h0004, 32'h0);
        cycle(2'b11, "s5");
        m_req = '0;
        cycle(2'b00, "s5_rsp");

        drv(0, 1'b1, 4'h0, 16'h0000, 32'h0);
        cycle(2'b01, "s6_rd");
        #1 rst = 1'b1;
        #1;
        chk({62'b0, m_rvalid}, 64'd0, "s6_rvalid_at_rst");
        chk(m_rdata, 64'd0, "s6_rdata_at_rst");
        q[0].delete();
        cycle(2'b00, "s6_rst");
        rst = 1'b0;
        m_req = '0;
        cycle(2'b00, "s6_post0");
        cycle(2'b00, "s6_post1");
        drv(0, 1'b1, 4'h0, 16'h0000, 32'h0);
        drv(1, 1'b1, 4'h0, 16'h0010, 32'h0);
        cycle(2'b01, "s6_cont");
        m_req = '0;
        cycle(2'b00, "s6_rsp");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
